// File: rtl/mms_pkg.sv
// Shared types and constants for the streaming max/min selector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mms_pkg;

    // FSM encoding kept as plain constants so older tools and code can share it
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ACC  = 2'd1;
    localparam state_t HOLD = 2'd2;

    // Reduction mode, latched from in_select on the first element of a frame
    localparam logic MMS_MAX = 1'b0;
    localparam logic MMS_MIN = 1'b1;

endpackage : mms_pkg

// File: rtl/mms_cmp_sel.sv
// Decides whether a candidate should replace the current best value.
// Latency: purely combinational.
// Backpressure: none; strict compare so ties keep the earlier element.
module mms_cmp_sel
    import mms_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] best,
    input  logic [DATA_W-1:0] cand,
    input  logic              mode,
    output logic              take
);

    // Unsigned strict comparison in the direction selected by mode
    assign take = (mode == MMS_MIN) ? (cand < best) : (cand > best);

endmodule : mms_cmp_sel

// File: rtl/mms_stream.sv
// Streaming max/min over frames of up to FRAME_LEN elements; optional winner index (MMS_INDEX_EN).
// Latency: result valid the cycle after the final element is accepted.
// Backpressure: in_ready drops while a result waits; result held stable until out_ready.
module mms_stream
    import mms_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_select,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count
`ifdef MMS_INDEX_EN
    ,
    output logic [CNT_W-1:0]  out_idx
`endif
);

    // Count value held just before the FRAME_LEN-th element arrives
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);

    state_t            state;
    logic [DATA_W-1:0] best;
    logic [CNT_W-1:0]  count;
    logic              mode;
    logic              take;
    logic              accept;
    logic              release_out;
    logic              frame_done;

    // Ready is gated by reset so nothing is taken during the reset cycle
    assign in_ready    = rst_n && (state != HOLD);
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state == HOLD);
    assign release_out = out_valid && out_ready;
    assign frame_done  = accept && (in_last || ((state == ACC) && (count == CNT_LAST)));

    assign out_data  = best;
    assign out_count = count;

    mms_cmp_sel #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .best (best),
        .cand (in_data),
        .mode (mode),
        .take (take)
    );

    // Frame sequencing: collect elements, then hold the result until it is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)      state <= in_last ? HOLD : ACC;
                ACC:     if (frame_done)  state <= HOLD;
                HOLD:    if (release_out) state <= IDLE;
                default:                  state <= IDLE;
            endcase
        end
    end

    // Running extremum, element count and latched mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best  <= '0;
            count <= '0;
            mode  <= MMS_MAX;
        end else if (accept) begin
            if (state == IDLE) begin
                best  <= in_data;
                mode  <= in_select;
                count <= CNT_W'(1);
            end else begin
                if (take) begin
                    best <= in_data;
                end
                if (count != CNT_FULL) begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

`ifdef MMS_INDEX_EN
    logic [CNT_W-1:0] idx;

    assign out_idx = idx;

    // Position of the current best; the incoming element's index equals the count so far
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                idx <= '0;
            end else if (take) begin
                idx <= count;
            end
        end
    end
`endif

endmodule : mms_stream

// File: tb/tb_mms_stream.sv
// Self-checking bench for mms_stream with a result scoreboard.
// Latency: checks result appears the cycle after the final accept.
// Backpressure: holds out_ready low and checks outputs stay stable.
module tb_mms_stream;

    typedef struct {
        logic [7:0] data;
        logic [2:0] count;
        logic [2:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_select;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_count;
`ifdef MMS_INDEX_EN
    logic [2:0] out_idx;
`endif

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mms_stream #(
        .DATA_W    (8),
        .FRAME_LEN (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_select (in_select),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
`ifdef MMS_INDEX_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    // Offer one element and wait (bounded) until it is accepted; returns at posedge+1
    task automatic send(input logic [7:0] d, input logic s, input logic l);
        int guard = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_select = s;
        in_last   = l;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Push the reference result for a frame, then drive its elements.
    // d holds element i in byte i; gap inserts idle cycles between elements.
    task automatic run_frame(input logic [31:0] d, input int n, input logic sel_first,
                             input logic sel_rest, input int gap, input logic push);
        exp_t       e;
        logic [7:0] v;
        logic       m;
        m      = sel_first;
        e.data = d[7:0];
        e.idx  = 3'd0;
        e.count = 3'(n);
        for (int i = 1; i < n; i++) begin
            v = d[8*i +: 8];
            if (m ? (v < e.data) : (v > e.data)) begin
                e.data = v;
                e.idx  = 3'(i);
            end
        end
        if (push) sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            send(d[8*i +: 8], (i == 0) ? sel_first : sel_rest, (n < 4) && (i == n - 1));
            if (i != n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    // Wait for a result, compare against the scoreboard, hold it back, then take it
    task automatic pop_result(input string name, input int hold);
        exp_t e;
        int   guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_valid_timeout: out_valid=%b required 1", name, out_valid);
            return;
        end
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_unexpected: result %0d with empty scoreboard", name, out_data);
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (out_data !== e.data) begin
            miscompares++;
            $display("FAIL %s_data: got %0d required %0d", name, out_data, e.data);
        end
        vectors++;
        if (out_count !== e.count) begin
            miscompares++;
            $display("FAIL %s_count: got %0d required %0d", name, out_count, e.count);
        end
`ifdef MMS_INDEX_EN
        vectors++;
        if (out_idx !== e.idx) begin
            miscompares++;
            $display("FAIL %s_idx: got %0d required %0d", name, out_idx, e.idx);
        end
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.data ||
                out_count !== e.count) begin
                miscompares++;
                $display("FAIL %s_hold%0d: valid=%b ready=%b data=%0d count=%0d required 1 0 %0d %0d",
                         name, i, out_valid, in_ready, out_data, out_count, e.data, e.count);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_release: valid=%b ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'd0 || out_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b valid=%b data=%0d count=%0d required 0 0 0 0",
                     in_ready, out_valid, out_data, out_count);
        end
`ifdef MMS_INDEX_EN
        vectors++;
        if (out_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_idx: got %0d required 0", out_idx);
        end
`endif
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_max_full;
        run_frame({8'd7, 8'd200, 8'd9, 8'd3}, 4, 1'b0, 1'b0, 0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL max_latency: valid=%b ready=%b required 1 0", out_valid, in_ready);
        end
        pop_result("max_full", 0);
    endtask

    task automatic test_min_full;
        run_frame({8'd80, 8'd5, 8'd5, 8'd50}, 4, 1'b1, 1'b1, 0, 1'b1);
        pop_result("min_tie", 0);
    endtask

    task automatic test_short;
        run_frame({16'd0, 8'd4, 8'd12}, 2, 1'b0, 1'b0, 0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL short_latency: valid=%b required 1", out_valid);
        end
        pop_result("short2", 0);
        run_frame({24'd0, 8'hFF}, 1, 1'b0, 1'b0, 0, 1'b1);
        pop_result("single", 0);
    endtask

    task automatic test_backpressure;
        run_frame({8'd40, 8'd10, 8'd90, 8'd20}, 4, 1'b0, 1'b0, 0, 1'b1);
        pop_result("bp_hold", 5);
        // Next frame must be taken right after release; send() flags any stall
        run_frame({8'd1, 8'd2, 8'd250, 8'd3}, 4, 1'b1, 1'b1, 0, 1'b1);
        pop_result("bp_next", 0);
    endtask

    task automatic test_mode_latch;
        run_frame({8'd4, 8'd3, 8'd2, 8'd1}, 4, 1'b0, 1'b1, 2, 1'b1);
        pop_result("mode_latch", 0);
    endtask

    task automatic test_reset_mid;
        send(8'd33, 1'b0, 1'b0);
        send(8'd99, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'd0 || out_count !== 3'd0) begin
            miscompares++;
            $display("FAIL midreset_state: ready=%b valid=%b data=%0d count=%0d required 0 0 0 0",
                     in_ready, out_valid, out_data, out_count);
        end
        rst_n = 1'b1;
        #1;
        run_frame({8'd5, 8'd7, 8'd6, 8'd8}, 4, 1'b1, 1'b1, 0, 1'b1);
        pop_result("after_reset", 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_select = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_max_full();
        test_min_full();
        test_short();
        test_backpressure();
        test_mode_latch();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mms_stream
